// File: rtl/mips_alu.sv
// MIPS-style ALU (AND/OR/ADD/SUB/SLT/SLTU plus inverted-B logic ops) with carry, overflow and zero flags.
// Define ALU_OUTREG_EN to register all outputs (1-cycle latency); otherwise purely combinational.
module mips_alu #(
   parameter int LOGWIDTH = 5,
   localparam int W = 2**LOGWIDTH
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic [2:0]   F,
   output logic [W-1:0] Y,
   output logic         Cout,
   output logic         Oflow,
   output logic         Zero
);

   logic         sub;
   logic [W-1:0] bb;
   logic [W-1:0] s;
   logic         c;
   logic         ov;
   logic [W-1:0] res;
   logic         rescout;
   logic         resov;
   logic         reszero;

   // SLTU (011) shares the adder in subtract mode, so c doubles as c' there.
   assign sub      = F[2] | (F[1] & F[0]);
   assign bb       = sub ? ~B : B;
   assign {c, s}   = {1'b0, A} + {1'b0, bb} + {{W{1'b0}}, sub};
   assign ov       = (A[W-1] == bb[W-1]) && (s[W-1] != A[W-1]);

   always_comb begin
      res     = '0;
      rescout = 1'b0;
      resov   = 1'b0;
      case (F)
         3'b000: res = A & B;
         3'b001: res = A | B;
         3'b010: begin
            res     = s;
            rescout = c;
            resov   = ov;
         end
         3'b011: begin
            res     = {{(W-1){1'b0}}, ~c};
            rescout = c;
         end
         3'b100: res = A & ~B;
         3'b101: res = A | ~B;
         3'b110: begin
            res     = s;
            rescout = c;
            resov   = ov;
         end
         3'b111: begin
            res     = {{(W-1){1'b0}}, s[W-1] ^ ov};
            rescout = c;
            resov   = ov;
         end
      endcase
   end

   assign reszero = ~|res;

`ifdef ALU_OUTREG_EN
   // Reset takes priority; Zero is taken from the same next-state result as Y.
   always_ff @(posedge clk) begin
      if (!reset) begin
         Y     <= '0;
         Cout  <= 1'b0;
         Oflow <= 1'b0;
         Zero  <= 1'b1;
      end else begin
         Y     <= res;
         Cout  <= rescout;
         Oflow <= resov;
         Zero  <= reszero;
      end
   end
`else
   logic unused;
   assign unused = clk ^ reset;

   assign Y     = res;
   assign Cout  = rescout;
   assign Oflow = resov;
   assign Zero  = reszero;
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard testbench for mips_alu: expected results are queued at drive time and checked when due.
module tb_mips_alu;

`ifdef ALU_OUTREG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      logic [31:0] y;
      logic        cout;
      logic        oflow;
      logic        zero;
      int          due;
      int          seq;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [2:0]  F = '0;
   logic [31:0] Y;
   logic        Cout, Oflow, Zero;

   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;
   int   seqNum = 0;
   exp_t sb[$];

   mips_alu #(.LOGWIDTH(5)) dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .F(F),
      .Y(Y), .Cout(Cout), .Oflow(Oflow), .Zero(Zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Independent reference model built on wide signed/unsigned arithmetic.
   function automatic exp_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      sa, sb2, r;
      logic [32:0] addw;
      logic [32:0] subw;
      logic        ovAdd, ovSub, geu;
      sa    = longint'($signed(a));
      sb2   = longint'($signed(b));
      addw  = {1'b0, a} + {1'b0, b};
      subw  = {1'b0, a} - {1'b0, b};
      geu   = (a >= b);
      r     = sa + sb2;
      ovAdd = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      r     = sa - sb2;
      ovSub = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      e.cout  = 1'b0;
      e.oflow = 1'b0;
      case (f)
         3'b000: e.y = a & b;
         3'b001: e.y = a | b;
         3'b010: begin e.y = addw[31:0]; e.cout = addw[32]; e.oflow = ovAdd; end
         3'b011: begin e.y = (a < b) ? 32'd1 : 32'd0; e.cout = geu; end
         3'b100: e.y = a & ~b;
         3'b101: e.y = a | ~b;
         3'b110: begin e.y = subw[31:0]; e.cout = geu; e.oflow = ovSub; end
         default: begin e.y = (sa < sb2) ? 32'd1 : 32'd0; e.cout = geu; e.oflow = ovSub; end
      endcase
      e.zero = (e.y == 32'd0);
      e.due  = 0;
      e.seq  = 0;
      return e;
   endfunction

   task automatic applyStimulus(input logic rst, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst;
      F     = f;
      A     = a;
      B     = b;
      if (LAT == 1 && !rst) begin
         e.y = '0; e.cout = 1'b0; e.oflow = 1'b0; e.zero = 1'b1;
      end else begin
         e = model(f, a, b);
      end
      e.due = cycle + LAT;
      e.seq = seqNum++;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cycle) begin
         exp_t e;
         e = sb.pop_front();
         checkOutput($sformatf("y#%0d", e.seq), Y, e.y);
         checkOutput($sformatf("flags#%0d", e.seq), {29'd0, Cout, Oflow, Zero},
                     {29'd0, e.cout, e.oflow, e.zero});
      end
   end

   initial begin
      logic [31:0] ra, rb;
      $display("[TB] mips_alu scoreboard test, latency %0d", LAT);
      applyStimulus(1'b0, 3'b010, 32'd5, 32'd3);
      applyStimulus(1'b0, 3'b010, 32'd7, 32'd9);
      applyStimulus(1'b1, 3'b010, 32'd2, 32'd3);
      applyStimulus(1'b1, 3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
      applyStimulus(1'b1, 3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
      applyStimulus(1'b1, 3'b110, 32'h0000_0005, 32'h0000_0005);
      applyStimulus(1'b1, 3'b110, 32'h8000_0000, 32'h0000_0001);
      applyStimulus(1'b1, 3'b111, 32'h8000_0000, 32'h0000_0001);
      applyStimulus(1'b1, 3'b111, 32'h0000_0001, 32'h8000_0000);
      applyStimulus(1'b1, 3'b011, 32'h0000_0001, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 3'b011, 32'hFFFF_FFFF, 32'h0000_0001);
      applyStimulus(1'b1, 3'b011, 32'h1234_5678, 32'h1234_5678);
      applyStimulus(1'b1, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
      applyStimulus(1'b1, 3'b001, 32'hF0F0_F0F0, 32'h0F00_0F00);
      applyStimulus(1'b1, 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00);
      applyStimulus(1'b1, 3'b101, 32'h0000_0000, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 3'b000, 32'h0000_0000, 32'hFFFF_FFFF);
      for (int i = 0; i < 64; i++) begin
         ra = $urandom;
         rb = (i % 5 == 0) ? ra : $urandom;
         if (i % 7 == 3) rb = ra ^ 32'h8000_0000;
         applyStimulus(1'b1, 3'(i % 8), ra, rb);
      end
      applyStimulus(1'b0, 3'b001, 32'hAAAA_AAAA, 32'h5555_5555);
      applyStimulus(1'b1, 3'b010, 32'd2, 32'd3);
      for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("drain", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
